// File: rtl/jt89_regs_if.sv
// CPU bus for the JT89 register file.
//   cs_n  : chip select, active-low         (master -> slave)
//   wr_n  : write strobe, active-low        (master -> slave)
//   din   : data byte                       (master -> slave)
//   ready : 1 = chip can accept a write     (slave -> master)
interface jt89_regs_if;
   logic       cs_n;
   logic       wr_n;
   logic [7:0] din;
   logic       ready;

   modport master (output cs_n, output wr_n, output din, input ready);
   modport slave  (input cs_n, input wr_n, input din, output ready);
endinterface

// File: rtl/jt89_regs.sv
// JT89 PSG register file and SN76489-style write decoder.
// Decodes latch/data bytes into three tone periods, four attenuations and the
// noise control. It also produces the LFSR clear pulse and the READY busy window.
//   clk, rst : system clock, async active-high reset
//   clken    : PSG clock enable, used only by the busy counter
//   bus      : cs_n / wr_n / din in, ready out
//   tone0..2 : 10-bit tone periods
//   vol0..3  : 4-bit attenuations (F = silent), vol3 is noise
//   ctrl3    : noise control ([2] white/periodic, [1:0] rate)
//   clr      : one-cycle pulse after every noise-control write
//
// state | meaning
// IDLE  | ready=1, writes accepted
// BUSY  | ready=0, busy counter running, writes discarded
module jt89_regs #(
   parameter int READY_EN     = 1,
   parameter int READY_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clken,
   jt89_regs_if.slave       bus,
   output logic [9:0]       tone0,
   output logic [9:0]       tone1,
   output logic [9:0]       tone2,
   output logic [3:0]       vol0,
   output logic [3:0]       vol1,
   output logic [3:0]       vol2,
   output logic [3:0]       vol3,
   output logic [2:0]       ctrl3,
   output logic             clr
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       wr_act_q, wr_act_d;
   logic [1:0] latch_chan_q, latch_chan_d;
   logic       latch_type_q, latch_type_d;
   logic [9:0] tone_q [3];
   logic [9:0] tone_d [3];
   logic [3:0] vol_q [4];
   logic [3:0] vol_d [4];
   logic [2:0] ctrl3_q, ctrl3_d;
   logic       clr_q, clr_d;

   logic       ready_ok;
   logic       accept;
   logic [1:0] chan;
   logic       typ;

   assign wr_act_d = !bus.cs_n && !bus.wr_n;
   assign ready_ok = (READY_EN == 0) || (state_q == ST_IDLE);
   // Only the first edge of a strobe counts, and only while not busy.
   assign accept   = wr_act_d && !wr_act_q && ready_ok;
   // Latch bytes carry their own target; data bytes reuse the stored latch.
   assign chan     = bus.din[7] ? bus.din[6:5] : latch_chan_q;
   assign typ      = bus.din[7] ? bus.din[4]   : latch_type_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      latch_chan_d = latch_chan_q;
      latch_type_d = latch_type_q;
      tone_d       = tone_q;
      vol_d        = vol_q;
      ctrl3_d      = ctrl3_q;
      clr_d        = 1'b0;

      if (accept) begin
         if (bus.din[7]) begin
            latch_chan_d = bus.din[6:5];
            latch_type_d = bus.din[4];
         end
         if (typ) begin
            vol_d[chan] = bus.din[3:0];
         end else if (chan == 2'd3) begin
            ctrl3_d = bus.din[2:0];
            clr_d   = 1'b1;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (chan == 2'(i)) begin
                  if (bus.din[7]) tone_d[i][3:0] = bus.din[3:0];
                  else            tone_d[i][9:4] = bus.din[5:0];
               end
            end
         end
         if (READY_EN != 0) begin
            state_d = ST_BUSY;
            cnt_d   = 8'(READY_CYCLES);
         end
      end else if (state_q == ST_BUSY && clken && cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
         if (cnt_q == 8'd1) state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         wr_act_q     <= 1'b0;
         latch_chan_q <= 2'd0;
         latch_type_q <= 1'b0;
         for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
         for (int i = 0; i < 4; i++) vol_q[i]  <= 4'hF;
         ctrl3_q      <= 3'd0;
         clr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_act_q     <= wr_act_d;
         latch_chan_q <= latch_chan_d;
         latch_type_q <= latch_type_d;
         tone_q       <= tone_d;
         vol_q        <= vol_d;
         ctrl3_q      <= ctrl3_d;
         clr_q        <= clr_d;
      end
   end

   assign bus.ready = ready_ok;
   assign tone0     = tone_q[0];
   assign tone1     = tone_q[1];
   assign tone2     = tone_q[2];
   assign vol0      = vol_q[0];
   assign vol1      = vol_q[1];
   assign vol2      = vol_q[2];
   assign vol3      = vol_q[3];
   assign ctrl3     = ctrl3_q;
   assign clr       = clr_q;

endmodule

// File: doc/jt89_regs.md
Name: jt89_regs

Overview:
- CPU-side register file and write decoder for the JT89 PSG.
- Accepts SN76489-format byte writes and decodes latch and data bytes into three 10-bit tone periods, four 4-bit attenuations and the 3-bit noise control.
- Generates the one-cycle noise-shift-register clear pulse and the READY wait handshake.
- Drives the tone channels and jt89_noise (ctrl3, vol, clr) directly.

Parameters:
- READY_EN, 1, when 1 implements the READY busy window; when 0, ready is tied to 1 and no write is ever ignored.
- READY_CYCLES, 32, length of the busy window in clken cycles (range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clken  in  1  PSG clock enable; used only by the READY counter
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low
- din  in  8  CPU data byte
- ready  out  1  1 = chip can accept a write
- tone0  out  10  channel 0 tone period
- tone1  out  10  channel 1 tone period
- tone2  out  10  channel 2 tone period
- vol0  out  4  channel 0 attenuation
- vol1  out  4  channel 1 attenuation
- vol2  out  4  channel 2 attenuation
- vol3  out  4  noise attenuation
- ctrl3  out  3  noise control: [2] white/periodic, [1:0] rate
- clr  out  1  one-cycle pulse; clears the noise LFSR

Behaviour:
- Reset (async, rst=1):
  - tone0..2=0, vol0..3=4'hF (silent), ctrl3=0.
  - Latched channel=0, latched type=0 (tone).
  - clr=0, ready=1, busy counter=0, write-edge history=inactive.
  - Reset asserted mid-busy forces ready=1 immediately.
- Write detection:
  - wr_act = !cs_n && !wr_n, sampled every clk edge (not gated by clken).
  - A write is accepted at an edge where wr_act=1, the previous sampled wr_act=0, and ready=1.
  - A held strobe yields exactly one write.
  - A write arriving while ready=0 is discarded entirely: no register change, no clr, counter not restarted.
- Latch byte (din[7]=1):
  - chan=din[6:5], type=din[4] (1=volume); both are stored as the latch.
  - type=1: vol[chan] <= din[3:0].
  - type=0, chan 0..2: tone[chan][3:0] <= din[3:0]; bits [9:4] are unchanged.
  - type=0, chan 3: ctrl3 <= din[2:0]; din[3] is ignored; clr pulses.
- Data byte (din[7]=0): acts on the stored latch.
  - Tone latch, chan 0..2: tone[chan][9:4] <= din[5:0]; bits [3:0] are unchanged.
  - Volume latch: vol[chan] <= din[3:0].
  - Noise control latch: ctrl3 <= din[2:0]; clr pulses.
  - din[6] is always ignored.
- Update latency:
  - Register outputs update on the accepting edge and are visible the following cycle.
  - clr is high for exactly one clk cycle, the cycle after the accepting edge.
  - Every noise-control write pulses clr, even if ctrl3 is rewritten with the same value.
- READY (READY_EN=1):
  - On an accepted write: ready <= 0 and counter <= READY_CYCLES, on the same edge.
  - While the counter is nonzero, it decrements on each clk edge with clken=1.
  - On the edge where the counter goes 1 -> 0, ready <= 1.
  - A write arriving at that same edge sees ready=0 and is discarded.
  - If clken is stuck at 0, ready stays low indefinitely.
- FSM: two states, IDLE (ready=1) and BUSY (ready=0).
  - IDLE -> BUSY on an accepted write.
  - BUSY -> IDLE when the counter reaches 0.
- Widths: all register fields are direct bit copies; there is no arithmetic except the 8-bit busy counter. The counter does not wrap, because it only decrements while nonzero.

Test Plan:
- Reset, then write 8'h8E followed by 8'h3F (each after ready=1) -> tone0=10'h3FE; the other tones stay 0; vol0..3=F; clr never pulses.
- Write 8'hD5 (ch2 volume) then data byte 8'h03 -> vol2=5 after the first write, vol2=3 after the second; tone2 unchanged.
- Write 8'hE6 -> ctrl3=3'b110 and a single clr pulse one cycle later; then data byte 8'h01 -> ctrl3=3'b001 and a second single clr pulse.
- READY_CYCLES=32, clken every 2nd clk, one write -> ready low for 64 clk cycles (±1); a second write issued at the midpoint is ignored (registers and counter unchanged); held wr_n=0 for 100 cycles produces only one write.
- Assert rst while ready=0 with tone1=10'h155 -> immediately ready=1 and tone1=0; the first write after deassertion is accepted.
- READY_EN=0: back-to-back writes on consecutive distinct strobes -> all accepted; ready constantly 1.
